// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch front end with a 2-entry fetch queue.
//
// The PC register drives the instruction ROM address directly. Each cycle a
// fetch is allowed and the queue has room (or its head is leaving), the
// {pc, rom_inst} pair is pushed and the PC advances by one word. The decode
// stage consumes the queue head with a valid/ready handshake. A redirect
// flushes the queue and reloads the PC with the word-aligned target.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   fetch_en        fetch permitted this cycle
//   rom_a           ROM byte address (ROM indexes by rom_a[7:2])
//   rom_inst        combinational ROM read data for rom_a
//   redirect_valid  branch/jump redirect request (beats push and pop)
//   redirect_pc     redirect target; low two bits are dropped
//   out_valid       queue head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_inst        head instruction word
//   out_pc          byte address of the head instruction
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t [1:0] queue;
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic [31:0]  pc;
    logic         pop;
    logic         push;

    // Target alignment discards these bits on purpose.
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];

    assign rom_a     = pc;
    assign out_valid = (count != 2'd0);
    assign out_inst  = queue[head].inst;
    assign out_pc    = queue[head].pc;

    assign pop  = out_valid && out_ready;
    // When full, a departing head frees the slot the new entry lands in.
    assign push = fetch_en && !redirect_valid && ((int'(count) < DEPTH) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            queue <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any handshake: the head is not consumed.
            pc    <= {redirect_pc[31:2], 2'b00};
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                // With the queue full, tail == head; the old head is read
                // out this cycle before being overwritten at the edge.
                queue[tail] <= '{pc: pc, inst: rom_inst};
                tail        <= ~tail;
                pc          <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] rom_a;
    logic [31:0] rom_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [31:0] rom [64];
    assign rom_inst = rom[rom_a[7:2]];

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .rom_a          (rom_a),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of fetched {pc, inst} pairs plus the PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("rom_a", rom_a, mpc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
    endtask

    // Drive one cycle's inputs, check the current outputs, advance the model
    // by the rules of the handshake, then cross the rising edge.
    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit   pop;
        bit   push;
        ent_t e;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        check_outs();
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = fe && ((mq.size() < 2) || pop);
            e    = '{pc: mpc, inst: rom[mpc[7:2]]};
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_outs();
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] img [4];
        img[0] = 32'h44000001;
        img[1] = 32'h28014024;
        img[2] = 32'h00202124;
        img[3] = 32'h14001005;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        for (int i = 0; i < 4; i++) rom[i] = img[i];
        model_reset();

        @(negedge clk);
        do_reset();

        // Streaming from reset: one instruction per cycle after one cycle of latency.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            chk("seq_pc", out_pc, i * 4);
            chk("seq_inst", out_inst, img[i]);
            chk("seq_valid", {31'b0, out_valid}, 32'd1);
        end

        // Back-pressure from reset: queue saturates, PC holds at 8.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("bp_rom_a", rom_a, 32'h8);
        chk("bp_pc", out_pc, 32'h0);
        chk("bp_inst", out_inst, 32'h44000001);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            chk("drain_pc", out_pc, (i + 1) * 4);
        end

        // Redirect while full and ready: head not consumed, flush, aligned target.
        cycle(1'b1, 1'b1, 32'h0000_0013, 1'b1);
        chk("redir_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_rom_a", rom_a, 32'h10);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_pc", out_pc, 32'h10);

        // Redirect to the top word: PC wraps to zero.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc1", out_pc, 32'h0);

        // Back-to-back redirects, the second with fetch disabled: last one wins.
        cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0082, 1'b1);
        chk("b2b_rom_a", rom_a, 32'h80);
        chk("b2b_valid", {31'b0, out_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("b2b_pc", out_pc, 32'h80);

        // Fill, then pulse reset between edges: outputs clear immediately.
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_async_valid", {31'b0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rom_a", rom_a, RESET_PC);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("post_async_pc", out_pc, RESET_PC);

        // fetch_en low drains the queue and holds the PC; resuming continues from it.
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_valid", {31'b0, out_valid}, 32'd0);
        chk("hold_rom_a", rom_a, 32'h4);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("resume_pc", out_pc, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom_range(0, 2) != 0);
        end
        #1;
        check_outs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, fetch address loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: DEPTH, 2, fetch-queue entries; fixed at 2, no other value supported.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: fetch_en  in  1  fetch permitted this cycle.
REQ-007 Port: rom_a  out  32  instruction ROM byte address; ROM indexes by rom_a[7:2].
REQ-008 Port: rom_inst  in  32  combinational ROM read data for rom_a.
REQ-009 Port: redirect_valid  in  1  branch/jump redirect request.
REQ-010 Port: redirect_pc  in  32  redirect target byte address.
REQ-011 Port: out_valid  out  1  queue head holds a valid instruction.
REQ-012 Port: out_ready  in  1  decode stage accepts head this cycle.
REQ-013 Port: out_inst  out  32  head instruction word.
REQ-014 Port: out_pc  out  32  byte address of head instruction.

Function
REQ-015 PC register SHALL drive rom_a directly (rom_a = pc, no combinational path from inputs).
REQ-016 Queue: 2-entry FIFO of {pc, inst}, head/tail pointers plus count 0..2.
REQ-017 pop = out_valid && out_ready.
REQ-018 push = fetch_en && !redirect_valid && (count < 2 || pop).
REQ-019 On push: tail <= {pc, rom_inst}, pc <= pc + 4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-020 No push: pc held.
REQ-021 Count update: push&&!pop +1; pop&&!push -1; both or neither unchanged.
REQ-022 Full (count=2) with pop: push SHALL occur, count stays 2, no entry lost or duplicated.
REQ-023 Empty (count=0): out_valid=0; out_ready ignored; no bypass -- instruction fetched in cycle N first visible on out_valid in cycle N+1.
REQ-024 out_valid = (count != 0); out_inst/out_pc = head entry, stable while out_valid && !out_ready.
REQ-025 Redirect (redirect_valid=1) SHALL take priority over push and pop: count <= 0, pointers reset, pc <= {redirect_pc[31:2], 2'b00}; head not consumed that cycle.
REQ-026 Misaligned redirect_pc SHALL be silently word-aligned, no error flag.
REQ-027 Redirect with fetch_en=0 SHALL still flush and load pc.
REQ-028 Cycle after redirect: out_valid=0; first target instruction valid one cycle after its push.
REQ-029 Back-to-back redirects: last one wins; no intermediate instruction emitted.
REQ-030 Sustained throughput with out_ready=1 and fetch_en=1: one instruction per cycle after initial 1-cycle latency.

Reset
REQ-031 While rst=1 (asynchronously): pc=RESET_PC, rom_a=RESET_PC, count=0, pointers=0, out_valid=0, out_inst=0, out_pc=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect.
REQ-033 First push SHALL occur on the first rising edge after rst deasserts with fetch_en=1.

Verification
REQ-034 Reset release, fetch_en=1, out_ready=1, ROM per program image -> out_pc 0,4,8,... on consecutive cycles starting one cycle after release, out_inst 44000001, 28014024, 00202124, 14001005.
REQ-035 out_ready=0 for 5 cycles from reset -> count saturates at 2, pc held at 8, out_pc=0/out_inst=44000001 stable; out_ready=1 -> out_pc 0,4,8 with no gap.
REQ-036 Queue full and redirect_valid=1, redirect_pc=32'h00000013, out_ready=1 same cycle -> head not consumed, out_valid=0 next cycle, rom_a=32'h10, then out_pc=32'h10.
REQ-037 Redirect to 32'hFFFFFFFC, fetch_en=1 -> out_pc sequence FFFFFFFC then 00000000.
REQ-038 rst pulsed asynchronously between clock edges with count=2 -> out_valid=0 and rom_a=RESET_PC immediately, before next edge.
REQ-039 fetch_en=0 with count=1, out_ready=1 -> entry drained, out_valid=0, pc unchanged; fetch_en=1 resumes at held pc.
